// File: rtl/if_id_fifo.sv
// IF/ID decoupling queue: buffers fetched instructions and presents one
// registered instruction per cycle to ID, honouring ID stall and pipeline flush.
module if_id_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic [5:0]        stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage has no reset so it can map onto RAM; only pointers and count are defined.
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              full_reg, full_next;
    logic              empty_reg, empty_next;
    logic              id_valid_reg, id_valid_next;
    logic [ADDR_W-1:0] id_pc_reg, id_pc_next;
    logic [INST_W-1:0] id_inst_reg, id_inst_next;

    logic push;
    logic pop;
    logic id_stall;

    assign id_stall = stall[2];
    assign push     = if_valid && !full_reg;
    assign pop      = !id_stall && !empty_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        id_valid_next = id_valid_reg;
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;

        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            id_valid_next = 1'b0;
            id_pc_next    = '0;
            id_inst_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
                id_valid_next = 1'b1;
                id_pc_next    = pc_mem[rd_ptr_reg];
                id_inst_next  = inst_mem[rd_ptr_reg];
            end else if (!id_stall) begin
                // Nothing queued and ID free: hand ID a bubble.
                id_valid_next = 1'b0;
                id_pc_next    = '0;
                id_inst_next  = '0;
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end

        full_next  = (count_next == CNT_W'(DEPTH));
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            id_valid_reg <= 1'b0;
            id_pc_reg    <= '0;
            id_inst_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            id_valid_reg <= id_valid_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
        end
    end

    // Writes are gated by full, so a full queue is never overwritten.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= if_pc;
            inst_mem[wr_ptr_reg] <= if_inst;
        end
    end

    assign if_ready = !full_reg;
    assign id_valid = id_valid_reg;
    assign id_pc    = id_pc_reg;
    assign id_inst  = id_inst_reg;
    assign count    = count_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;

endmodule
